seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display. It holds a double-buffered digit image and scans one digit at a time with a programmable dwell. Each digit slot starts with an anti-ghosting blank interval. Per-digit decimal points, optional hex glyphs and leading-zero suppression are supported. It sits between the clock/counter datapath and the board's segment and anode pins, and replaces per-digit static decoders.

## Interface
Parameters:
- DIGITS, 4: number of digits, legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ BLANK_CYC+2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- DIN  in  4*DIGITS  digit values; nibble i is digit i, and digit 0 is the rightmost.
- DOT  in  DIGITS  decimal-point enable per digit.
- LOAD  in  1  single-cycle strobe that captures DIN/DOT into the shadow buffer.
- HEX_EN  in  1  1 = show A–F glyphs; 0 = values 10–15 blank.
- BLANK_LZ  in  1  1 = suppress leading zeros.
- SEG  out  8  active-low segments; bits 6..0 = g..a, bit 7 = dp.
- AN  out  DIGITS  active-low one-hot digit select.
- FRAME  out  1  one-cycle pulse when a new frame (digit 0) starts.

## Operation
- **Prescaler and digit index.**
  - Prescaler p counts 0..SCAN_DIV-1.
  - Digit index d advances when p = SCAN_DIV-1, wrapping DIGITS-1 → 0.
- **Blank interval.** For p < BLANK_CYC, the internal anode vector is all 1 and segments are 8'hFF.
- **Active interval.** Otherwise AN[d]=0, and SEG carries the glyph of display nibble d.
- **Double buffering.**
  - LOAD writes DIN/DOT into the shadow registers and sets a pending flag.
  - On the wrap cycle (d = DIGITS-1, p = SCAN_DIV-1), the shadow is copied to display if pending, then pending is cleared.
  - If LOAD occurs on the wrap cycle itself, the loaded value is copied directly (same-cycle load wins).
  - Multiple LOADs within one frame: the last one wins.
- **Glyphs (before the dp bit).**
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - With HEX_EN=1: A=88, b=83, C=C6, d=A1, E=86, F=8E. With HEX_EN=0, values 10–15 are FF.
- **Dot.** When the display DOT bit for the digit is set, SEG[7] is forced to 0; otherwise it is 1.
- **Leading-zero suppression.**
  - With BLANK_LZ=1, digit i (i ≥ 1) is blanked (7 segment bits = 1) when nibble i and all higher nibbles are 0.
  - Digit 0 is never suppressed.
  - The dot is still shown on a suppressed digit.
- **Combinational mode inputs.** HEX_EN and BLANK_LZ are sampled live, not buffered.

## Timing
- **Reset values.**
  - SEG=8'hFF, AN=all 1, FRAME=0.
  - p=0, d=0.
  - Display and shadow registers all zero; pending=0.
- **Registered outputs.** SEG, AN and FRAME are registered: they reflect the state (p, d) of the previous cycle.
- **First cycle after reset.** The first cycle after RST deasserts has p=0, d=0. AN first goes low on the edge after p reaches BLANK_CYC.
- **FRAME.** Asserted for exactly one cycle, coincident with the AN/SEG output cycle of digit 0, p=0.
- **Digit slot.** Each digit's anode is active for SCAN_DIV-BLANK_CYC cycles. One frame lasts DIGITS*SCAN_DIV cycles.
- **LOAD-to-display latency.** 1 to DIGITS*SCAN_DIV cycles; data never changes mid-frame (no tearing).
- **Reset mid-operation.**
  - RST in any cycle returns every register to its reset value on that edge.
  - The outputs show FF / all-1 on the next cycle, and scanning restarts at digit 0.
  - A pending load is discarded.
- **Widths.**
  - p is $clog2(SCAN_DIV) bits.
  - d is max(1, $clog2(DIGITS)) bits; for non-power-of-2 DIGITS, d must never reach DIGITS.

## Structure
- **Package seg7_pkg:**
  - 7-bit glyph constants for 0–F;
  - SEG_OFF = 8'hFF;
  - DP_BIT = 7.
- **Sub-module seg7_glyph** (combinational):
  - inputs: value[3:0], hex_en, blank, dot;
  - output: seg[7:0].
- The top level holds the prescaler, digit index, shadow/display buffers, leading-zero mask and output registers.

## Test plan
Use DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- **Reset.** Hold RST 3 cycles, then release → SEG=FF, AN=F, FRAME=0 during reset. AN=4'b1110 first appears 3 cycles after release; FRAME pulses once every 32 cycles.
- **Decimal data with dot.** LOAD DIN=16'h1234, DOT=4'b0100 mid-frame → the current frame shows zeros (C0). From the next FRAME: digit0=99, digit1=B0, digit2=24, digit3=F9.
- **Leading-zero suppression.** BLANK_LZ=1, DIN=16'h0007 → digits 3..1 SEG=FF, digit0=F8. DIN=16'h0000 → digit0=C0, others FF. DIN=16'h0700 → digit3=FF, digit2=F8, digit1=C0, digit0=C0.
- **Hex mode.** HEX_EN=0, DIN=16'hABCD → all digits FF. HEX_EN=1 → digits 3..0 = 88, 83, C6, A1.
- **Load collisions.** LOAD 16'h5555 on the wrap cycle → shown from the immediately following frame. LOAD 16'h1111 then 16'h2222 in the same frame → the next frame shows only 2 (A4).
- **Reset during scanning.** RST asserted during digit 2's active interval → next cycle SEG=FF, AN=F. After release, scanning restarts at digit 0 and all digits show C0 (BLANK_LZ=0).

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table and segment constants for the 7-segment scan driver
package seg7_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam int DP_BIT = 7;
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;
  localparam logic [15:0][6:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: nibble to active-low segment pattern with dp, hex gating and blanking
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_en,
  input  logic       blank,
  input  logic       dot,
  output logic [7:0] seg
);
  logic off;
  always_comb begin
    off = blank || (value > 4'd9 && !hex_en);
    seg = {~dot, off ? SEG_OFF[6:0] : GLYPHS[value]};
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed common-anode 7-segment scanner
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DIN,
  input  logic [DIGITS-1:0]     DOT,
  input  logic                  LOAD,
  input  logic                  HEX_EN,
  input  logic                  BLANK_LZ,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] LAST_P  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYC);
  localparam logic [DW-1:0] LAST_D  = DW'(DIGITS - 1);
  logic [PW-1:0] p;
  logic [DW-1:0] d;
  logic [3:0] shadow [DIGITS];
  logic [3:0] disp [DIGITS];
  logic [DIGITS-1:0] shadow_dot, disp_dot, lz;
  logic pending, last_p, wrap, blank_now, zero_run;
  logic [7:0] glyph_seg;
  assign last_p    = p == LAST_P;
  assign wrap      = last_p && d == LAST_D;
  assign blank_now = p < BLANK_P;
  // a digit is a leading zero when it and every digit to its left are zero
  always_comb begin
    lz = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && disp[i] == 4'h0;
      lz[i] = BLANK_LZ && zero_run;
    end
  end
  seg7_glyph u_glyph (
    .value (disp[d]),
    .hex_en(HEX_EN),
    .blank (lz[d]),
    .dot   (disp_dot[d]),
    .seg   (glyph_seg)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      p <= '0;
      d <= '0;
      pending <= 1'b0;
      shadow_dot <= '0;
      disp_dot <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= '0;
        disp[i] <= '0;
      end
      SEG <= SEG_OFF;
      AN <= '1;
      FRAME <= 1'b0;
    end else begin
      p <= last_p ? '0 : p + 1'b1;
      if (last_p) d <= wrap ? '0 : d + 1'b1;
      if (LOAD) begin
        shadow_dot <= DOT;
        for (int i = 0; i < DIGITS; i++) shadow[i] <= DIN[4*i +: 4];
      end
      pending <= !wrap && (pending || LOAD);
      // frame boundary swap; a load on this very cycle bypasses the shadow
      if (wrap && (pending || LOAD)) begin
        disp_dot <= LOAD ? DOT : shadow_dot;
        for (int i = 0; i < DIGITS; i++) disp[i] <= LOAD ? DIN[4*i +: 4] : shadow[i];
      end
      SEG <= blank_now ? SEG_OFF : glyph_seg;
      AN <= blank_now ? '1 : ~(DIGITS'(1) << d);
      FRAME <= p == '0 && d == '0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed checks against a cycle-count reference model
module tb_seg7_scan_driver;
  localparam int ND = 4, DIV = 8, BLK = 2, FR = ND * DIV;
  logic clk = 0, rst = 1, load = 0, hex_en = 0, blank_lz = 0;
  logic [15:0] din = '0;
  logic [3:0] dot = '0, an;
  logic [7:0] seg;
  logic frame;
  int checks = 0, errors = 0, c = 0;
  logic [15:0] latest = '0, shown = '0;
  logic [3:0] latest_dot = '0, shown_dot = '0;
  logic [7:0] gl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  seg7_scan_driver #(.DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .CLK(clk), .RST(rst), .DIN(din), .DOT(dot), .LOAD(load), .HEX_EN(hex_en),
    .BLANK_LZ(blank_lz), .SEG(seg), .AN(an), .FRAME(frame)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at t=%0t cycle=%0d: got %h expected %h", tag, $time, c, got, exp);
    end
  endtask
  // c is the cycle count since reset release; digit/phase/frame follow from it arithmetically
  task automatic step();
    logic [7:0] es, g;
    logic [3:0] ea, nib;
    logic ef;
    int pp, dd;
    if (rst) begin
      es = 8'hFF; ea = 4'hF; ef = 1'b0;
    end else begin
      pp = c % DIV;
      dd = (c / DIV) % ND;
      nib = 4'((shown >> (4 * dd)) & 16'hF);
      g = gl[nib];
      if ((blank_lz && dd > 0 && (shown >> (4 * dd)) == 0) || (nib > 9 && !hex_en)) g = 8'hFF;
      es = pp < BLK ? 8'hFF : {~shown_dot[dd], g[6:0]};
      ea = pp < BLK ? 4'hF : ~(4'b0001 << dd);
      ef = c % FR == 0;
    end
    if (rst) begin
      c = 0; latest = '0; shown = '0; latest_dot = '0; shown_dot = '0;
    end else begin
      if (load) begin latest = din; latest_dot = dot; end
      if (c % FR == FR - 1) begin shown = latest; shown_dot = latest_dot; end
      c++;
    end
    @(posedge clk);
    #1;
    check("seg", {24'h0, seg}, {24'h0, es});
    check("an", {28'h0, an}, {28'h0, ea});
    check("frame", {31'h0, frame}, {31'h0, ef});
    load = 0;
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic run_until(int ph);
    for (int i = 0; i < 2 * FR && c % FR != ph; i++) step();
  endtask
  task automatic do_load(logic [15:0] v, logic [3:0] dp);
    din = v; dot = dp; load = 1;
    step();
  endtask
  initial begin
    run(3);
    rst = 0;
    run(2);
    check("an_before_active", {28'h0, an}, 32'hF);
    step();
    check("an_first_active", {28'h0, an}, 32'hE);
    run(5);
    check("zeros_shown", {24'h0, seg}, 32'hC0);
    do_load(16'h1234, 4'b0100);
    run_until(FR - 1); step();
    run_until(20); step();
    check("dig2_dot", {24'h0, seg}, 32'h24);
    run(40);
    blank_lz = 1;
    do_load(16'h0007, 4'b0000); run(2 * FR);
    do_load(16'h0000, 4'b0000); run(2 * FR);
    do_load(16'h0700, 4'b0000); run(2 * FR);
    blank_lz = 0; hex_en = 0;
    do_load(16'hABCD, 4'b0000); run(2 * FR);
    hex_en = 1; run(FR);
    run_until(FR - 1);
    do_load(16'h5555, 4'b0000);
    run_until(2); step();
    check("wrap_load", {24'h0, seg}, 32'h92);
    run(10);
    do_load(16'h1111, 4'b0000); run(3);
    do_load(16'h2222, 4'b0000);
    run_until(FR - 1); step();
    run_until(26); step();
    check("last_load_wins", {24'h0, seg}, 32'hA4);
    run_until(20);
    rst = 1; step();
    check("rst_mid_seg", {24'h0, seg}, 32'hFF);
    check("rst_mid_an", {28'h0, an}, 32'hF);
    rst = 0;
    run(FR + 4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin din = 16'($urandom); dot = 4'($urandom); load = 1; end
      if ($urandom_range(0, 49) == 0) hex_en = ~hex_en;
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      rst = $urandom_range(0, 499) == 0;
      step();
    end
    rst = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
